skew_addr_gen: RTL and testbench

SKEW_ADDR_GEN -- requirements
Module: skew_addr_gen

---
 rtl/skew_addr_gen.sv | 108 ++++++++++
 tb/tb_skew_addr_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/skew_addr_gen.sv
// skew_addr_gen: per-lane tile address sequencer with optional systolic diagonal skew.
module skew_addr_gen #(
  parameter int ARRAY_DIM = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        active,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [CNT_W-1:0]            num_row,
  input  logic [CNT_W-1:0]            num_col,
  input  logic [ADDR_W-1:0]           stride,
  input  logic                        skew_en,
  input  logic                        stall,
  output logic [ARRAY_DIM*ADDR_W-1:0] out_addr,
  output logic [ARRAY_DIM-1:0]        out_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int TW = CNT_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, stride_q, stride_d;
  logic [CNT_W-1:0] rows_q, rows_d, cols_q, cols_d, rows_in, cols_in;
  logic skew_q, skew_d, busy_q, busy_d, done_q, done_d, start;
  logic [TW-1:0] t_q, t_d, step, total, off, r;
  logic [ARRAY_DIM*ADDR_W-1:0] addr_q, addr_d, lane_addr;
  logic [ARRAY_DIM-1:0] valid_q, valid_d, lane_valid;
  assign out_addr = addr_q;
  assign out_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
  // Lane values for the step about to be presented; in IDLE they come straight from the inputs being latched.
  always_comb begin
    start = (state_q == IDLE) && active;
    rows_in = (num_row > CNT_W'(ARRAY_DIM)) ? CNT_W'(ARRAY_DIM) : num_row;
    cols_in = (num_col > CNT_W'(ARRAY_DIM)) ? CNT_W'(ARRAY_DIM) : num_col;
    base_d = start ? base_addr : base_q;
    stride_d = start ? stride : stride_q;
    rows_d = start ? rows_in : rows_q;
    cols_d = start ? cols_in : cols_q;
    skew_d = start ? skew_en : skew_q;
    total = TW'(rows_q) + ((skew_q && cols_q != '0) ? TW'(cols_q) - TW'(1) : TW'(0));
    step = start ? '0 : t_q;
    off = '0;
    r = '0;
    lane_valid = '0;
    lane_addr = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      off = skew_d ? TW'(i) : '0;
      r = step - off;
      lane_valid[i] = (CNT_W'(i) < cols_d) && (step >= off) && (r < TW'(rows_d));
      lane_addr[i*ADDR_W +: ADDR_W] = lane_valid[i] ? base_d + ADDR_W'(r) * stride_d + ADDR_W'(i) : '0;
    end
  end
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    addr_d = addr_q;
    valid_d = valid_q;
    done_d = 1'b0;
    if (start) begin
      state_d = (rows_in == '0 || cols_in == '0) ? DONE : RUN;
      done_d = (state_d == DONE);
      t_d = TW'(1);
      addr_d = (state_d == DONE) ? '0 : lane_addr;
      valid_d = (state_d == DONE) ? '0 : lane_valid;
    end else if (state_q == RUN && !stall) begin
      state_d = (t_q == total) ? DONE : RUN;
      done_d = (state_d == DONE);
      t_d = t_q + TW'(1);
      addr_d = (state_d == DONE) ? '0 : lane_addr;
      valid_d = (state_d == DONE) ? '0 : lane_valid;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      t_d = '0;
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q <= '0;
      addr_q <= '0;
      valid_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      base_q <= '0;
      stride_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      skew_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      addr_q <= addr_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      base_q <= base_d;
      stride_q <= stride_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      skew_q <= skew_d;
    end
  end
endmodule

// File: tb/tb_skew_addr_gen.sv
// tb_skew_addr_gen: directed tiles checked every cycle against a tile-level model, plus literal spot checks.
module tb_skew_addr_gen;
  localparam int N = 16;
  localparam int AW = 8;
  localparam int CW = 5;
  logic clk = 1'b0, reset = 1'b1, active = 1'b0, skew_en = 1'b0, stall = 1'b0;
  logic [AW-1:0] base_addr = '0, stride = '0;
  logic [CW-1:0] num_row = '0, num_col = '0;
  logic [N*AW-1:0] out_addr;
  logic [N-1:0] out_valid;
  logic busy, done;
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  skew_addr_gen #(.ARRAY_DIM(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .active(active), .base_addr(base_addr), .num_row(num_row),
    .num_col(num_col), .stride(stride), .skew_en(skew_en), .stall(stall),
    .out_addr(out_addr), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: which step of which tile is on the outputs, expressed as phase plus step index k.
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t ph = M_IDLE;
  int k = 0, m_r = 0, m_c = 0;
  int m_base = 0, m_stride = 0;
  bit m_skew = 1'b0;

  function automatic int clamp(input int v);
    return (v > N) ? N : v;
  endfunction

  function automatic int steps();
    return m_r + ((m_skew && m_c > 0) ? m_c - 1 : 0);
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int rr = k - (m_skew ? i : 0);
      v[i] = (ph == M_RUN) && (i < m_c) && (rr >= 0) && (rr < m_r);
    end
    return v;
  endfunction

  function automatic logic [N*AW-1:0] exp_addr();
    logic [N*AW-1:0] a = '0;
    logic [N-1:0] v = exp_valid();
    for (int i = 0; i < N; i++) begin
      int rr = k - (m_skew ? i : 0);
      int full = m_base + rr * m_stride + i;
      logic [31:0] w = full;
      if (v[i]) a[i*AW +: AW] = w[AW-1:0];
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (reset) ph <= M_IDLE;
    else if (ph == M_IDLE) begin
      if (active) begin
        m_r <= clamp(int'(num_row));
        m_c <= clamp(int'(num_col));
        m_base <= int'(base_addr);
        m_stride <= int'(stride);
        m_skew <= skew_en;
        k <= 0;
        ph <= (clamp(int'(num_row)) == 0 || clamp(int'(num_col)) == 0) ? M_DONE : M_RUN;
      end
    end else if (ph == M_RUN) begin
      if (!stall) begin
        if (k + 1 < steps()) k <= k + 1;
        else ph <= M_DONE;
      end
    end else ph <= M_IDLE;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", out_valid, exp_valid());
      chk("model_addr", out_addr, exp_addr());
      chk("model_busy", busy, ph != M_IDLE);
      chk("model_done", done, ph == M_DONE);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a tile request, then scrambles the inputs so latching is exercised; returns in step 0.
  task automatic start(input int b, input int r, input int c, input int s, input bit sk);
    @(negedge clk);
    base_addr = AW'(b);
    num_row = CW'(r);
    num_col = CW'(c);
    stride = AW'(s);
    skew_en = sk;
    active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    base_addr = 8'h5A;
    num_row = 5'd3;
    num_col = 5'd7;
    stride = 8'h33;
    skew_en = ~sk;
  endtask

  function automatic logic [AW-1:0] lane(input int i);
    return out_addr[i*AW +: AW];
  endfunction

  initial begin
    tick(2);
    chk("reset_valid", out_valid, 0);
    chk("reset_addr", out_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    start(8'h00, 16, 16, 16, 1'b0);
    chk("aligned_s0_valid", out_valid, 16'hFFFF);
    chk("aligned_s0_lane5", lane(5), 8'h05);
    tick(15);
    chk("aligned_s15_lane3", lane(3), 8'hF3);
    tick(1);
    chk("aligned_done", done, 1);
    chk("aligned_done_valid", out_valid, 0);
    tick(1);
    chk("aligned_idle_busy", busy, 0);
    start(8'h00, 16, 16, 16, 1'b1);
    chk("skew_s0_valid", out_valid, 16'h0001);
    chk("skew_s0_lane0", lane(0), 8'h00);
    tick(15);
    chk("skew_s15_valid", out_valid, 16'hFFFF);
    chk("skew_s15_lane0", lane(0), 8'hF0);
    chk("skew_s15_lane15", lane(15), 8'h0F);
    tick(15);
    chk("skew_s30_valid", out_valid, 16'h8000);
    chk("skew_s30_lane15", lane(15), 8'hFF);
    tick(1);
    chk("skew_done", done, 1);
    start(8'hF0, 2, 2, 16, 1'b0);
    chk("wrap_s0_valid", out_valid, 16'h0003);
    chk("wrap_s0_addr", out_addr[15:0], 16'hF1F0);
    active = 1'b1;
    tick(1);
    active = 1'b0;
    chk("wrap_s1_addr", out_addr[15:0], 16'h0100);
    tick(1);
    chk("wrap_done", done, 1);
    tick(1);
    start(8'h10, 4, 4, 4, 1'b0);
    tick(1);
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick(1);
      chk("stall_hold_lane0", lane(0), 8'h14);
      chk("stall_hold_done", done, 0);
    end
    stall = 1'b0;
    tick(2);
    chk("stall_s3_lane3", lane(3), 8'h1F);
    tick(1);
    chk("stall_done", done, 1);
    tick(1);
    stall = 1'b1;
    start(8'h20, 0, 4, 4, 1'b0);
    stall = 1'b0;
    chk("zero_rows_done", done, 1);
    chk("zero_rows_valid", out_valid, 0);
    tick(1);
    chk("zero_rows_idle", busy, 0);
    start(8'h40, 1, 20, 1, 1'b0);
    chk("clamp_cols_valid", out_valid, 16'hFFFF);
    chk("clamp_cols_lane15", lane(15), 8'h4F);
    tick(2);
    start(8'h00, 16, 16, 16, 1'b0);
    tick(5);
    chk("rst_mid_s5_lane1", lane(1), 8'h51);
    reset = 1'b1;
    active = 1'b1;
    stall = 1'b1;
    tick(1);
    reset = 1'b0;
    active = 1'b0;
    stall = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    start(8'h08, 2, 2, 8, 1'b0);
    chk("after_rst_valid", out_valid, 16'h0003);
    chk("after_rst_addr", out_addr[15:0], 16'h0908);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
